// File: rtl/bit_stream_serializer.sv
// Parallel-to-serial feeder: captures a word of 1..WIDTH bits and shifts it out bit len-1 first, one bit per clock.
// Optional `SERIALIZER_LOOP_EN adds a `loop` input that restarts the captured word instead of finishing it.
module bit_stream_serializer #(
    parameter int WIDTH = 16,
    parameter int LEN_W = 5
) (
    input  logic             clk,
    input  logic             reset,
`ifdef SERIALIZER_LOOP_EN
    input  logic             loop,
`endif
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic [LEN_W-1:0] len,
    output logic             out,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_nxt;
    logic [LEN_W-1:0] r_cnt;
    logic [LEN_W-1:0] w_cnt_nxt;
    logic             r_out;
    logic             r_valid;
    logic             r_busy;
    logic             r_done;

    logic             w_accept;
    logic [LEN_W-1:0] w_len_eff;
    logic [WIDTH-1:0] w_aligned;

`ifdef SERIALIZER_LOOP_EN
    logic [WIDTH-1:0] r_word;
    logic [LEN_W-1:0] r_last_idx;
`endif

    // The word is left-aligned so the next bit to send always sits in the MSB.
    assign w_len_eff = (len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : len;
    assign w_aligned = data << (LEN_W'(WIDTH) - w_len_eff);
    assign w_accept  = load && (len != '0) && (r_state != ST_SHIFT);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;

        case (r_state)
            ST_SHIFT: begin
                if (r_cnt != '0) begin
                    w_shift_nxt = r_shift << 1;
                    w_cnt_nxt   = r_cnt - LEN_W'(1);
                end
`ifdef SERIALIZER_LOOP_EN
                else if (loop) begin
                    w_shift_nxt = r_word;
                    w_cnt_nxt   = r_last_idx;
                end
`endif
                else begin
                    w_state_nxt = ST_DONE;
                    w_shift_nxt = '0;
                end
            end
            ST_IDLE, ST_DONE: begin
                if (w_accept) begin
                    w_state_nxt = ST_SHIFT;
                    w_shift_nxt = w_aligned;
                    w_cnt_nxt   = w_len_eff - LEN_W'(1);
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Outputs are computed from the next state so they leave the block straight from flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_out   <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_cnt   <= w_cnt_nxt;
            r_out   <= (w_state_nxt == ST_SHIFT) && w_shift_nxt[WIDTH-1];
            r_valid <= (w_state_nxt == ST_SHIFT);
            r_busy  <= (w_state_nxt == ST_SHIFT);
            r_done  <= (w_state_nxt == ST_DONE);
        end
    end

`ifdef SERIALIZER_LOOP_EN
    // A copy of the captured word lets loop mode restart without the feeder re-presenting it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_word     <= '0;
            r_last_idx <= '0;
        end else if (w_accept) begin
            r_word     <= w_aligned;
            r_last_idx <= w_len_eff - LEN_W'(1);
        end
    end
`endif

    assign out   = r_out;
    assign valid = r_valid;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule

// File: tb/tb_bit_stream_serializer.sv
// Self-checking bench for bit_stream_serializer: directed vector table, hand-written corner sequences,
// and randomized traffic compared against a bit-stream queue model. Honours `SERIALIZER_LOOP_EN.
module tb_bit_stream_serializer;

    localparam int WIDTH = 16;
    localparam int LEN_W = 5;

    logic             clk   = 1'b0;
    logic             reset = 1'b0;
    logic             load  = 1'b0;
    logic [WIDTH-1:0] data  = '0;
    logic [LEN_W-1:0] len   = '0;
`ifdef SERIALIZER_LOOP_EN
    logic             loop  = 1'b0;
`endif
    logic             out;
    logic             valid;
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bit_stream_serializer #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk   (clk),
        .reset (reset),
`ifdef SERIALIZER_LOOP_EN
        .loop  (loop),
`endif
        .load  (load),
        .data  (data),
        .len   (len),
        .out   (out),
        .valid (valid),
        .busy  (busy),
        .done  (done)
    );

    // ---------------- reference model: queue of upcoming per-cycle outputs ----------------
    typedef struct packed {
        logic o;
        logic v;
        logic b;
        logic d;
        logic last;
    } rec_t;

    localparam rec_t IDLE_R = '{o: 1'b0, v: 1'b0, b: 1'b0, d: 1'b0, last: 1'b0};
    localparam rec_t DONE_R = '{o: 1'b0, v: 1'b0, b: 1'b0, d: 1'b1, last: 1'b0};

    rec_t             mq[$];
    rec_t             cur = IDLE_R;
    logic [WIDTH-1:0] m_word = '0;
    int               m_len  = 0;

    function automatic void push_word();
        rec_t r;
        for (int i = m_len - 1; i >= 0; i--) begin
            r = '{o: m_word[i], v: 1'b1, b: 1'b1, d: 1'b0, last: (i == 0)};
            mq.push_back(r);
        end
        mq.push_back(DONE_R);
    endfunction

    always @(posedge clk or negedge reset) begin
        logic lp;
        if (!reset) begin
            mq.delete();
            cur = IDLE_R;
        end else begin
`ifdef SERIALIZER_LOOP_EN
            lp = loop;
`else
            lp = 1'b0;
`endif
            if (cur.v && cur.last && lp) begin
                mq.delete();
                push_word();
            end else if (!cur.b && load && (len != 0)) begin
                m_word = data;
                m_len  = (int'(len) > WIDTH) ? WIDTH : int'(len);
                mq.delete();
                push_word();
            end
            cur = (mq.size() > 0) ? mq.pop_front() : IDLE_R;
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: {out,valid,busy,done} got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] dut_outs();
        return {out, valid, busy, done};
    endfunction

    function automatic logic [3:0] model_outs();
        return {cur.o, cur.v, cur.b, cur.d};
    endfunction

    // Advance one clock; inputs are driven at the negedge, outputs sampled at the next negedge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic             ld;
        logic [WIDTH-1:0] dt;
        logic [LEN_W-1:0] ln;
        logic [3:0]       exp;
        string            name;
    } vec_t;

    vec_t vt[$];

    function automatic void add(input logic ld, input logic [WIDTH-1:0] dt, input logic [LEN_W-1:0] ln,
                                input logic [3:0] exp, input string name);
        vec_t v;
        v.ld = ld; v.dt = dt; v.ln = ln; v.exp = exp; v.name = name;
        vt.push_back(v);
    endfunction

    initial begin
        logic [11:0] basic;
        basic = 12'h5D2;

        // Basic 12-bit word with an ignored load during its bit 3.
        add(1'b1, 16'h05D2, 5'd12, {basic[11], 3'b110}, "basic_b0");
        for (int i = 1; i < 12; i++)
            add(i == 3, (i == 3) ? 16'hFFFF : 16'h0000, 5'd16, {basic[11-i], 3'b110},
                $sformatf("basic_b%0d", i));
        add(1'b0, '0, '0, 4'b0001, "basic_done");
        add(1'b0, '0, '0, 4'b0000, "basic_idle");
        // Single bit, then a back-to-back load in the DONE cycle.
        add(1'b1, 16'h0001, 5'd1, 4'b1110, "single_bit");
        add(1'b0, '0, '0, 4'b0001, "single_done");
        add(1'b1, 16'h0002, 5'd2, 4'b1110, "b2b_b0");
        add(1'b0, '0, '0, 4'b0110, "b2b_b1");
        add(1'b0, '0, '0, 4'b0001, "b2b_done");
        add(1'b0, '0, '0, 4'b0000, "b2b_idle");
        // len=0 is ignored.
        add(1'b1, 16'hFFFF, 5'd0, 4'b0000, "len0_ignored");
        add(1'b0, '0, '0, 4'b0000, "len0_idle");
        // len=20 clamps to 16.
        add(1'b1, 16'h8001, 5'd20, 4'b1110, "clamp_b15");
        for (int i = 14; i >= 1; i--)
            add(1'b0, '0, '0, 4'b0110, $sformatf("clamp_b%0d", i));
        add(1'b0, '0, '0, 4'b1110, "clamp_b0");
        add(1'b0, '0, '0, 4'b0001, "clamp_done");
        add(1'b0, '0, '0, 4'b0000, "clamp_idle");

        // ---------------- reset state ----------------
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_state", dut_outs(), 4'b0000);
        reset = 1'b1;
        tick();
        check("post_reset_idle", dut_outs(), 4'b0000);

        // ---------------- table run ----------------
        foreach (vt[k]) begin
            load = vt[k].ld;
            data = vt[k].dt;
            len  = vt[k].ln;
            tick();
            check(vt[k].name, dut_outs(), vt[k].exp);
        end
        load = 1'b0;

        // ---------------- async reset mid-word ----------------
        load = 1'b1; data = 16'hFFFF; len = 5'd16;
        for (int i = 0; i <= 5; i++) begin
            tick();
            load = 1'b0;
            check($sformatf("rst_word_b%0d", i), dut_outs(), 4'b1110);
        end
        #1 reset = 1'b0;
        #1 check("rst_async_clear", dut_outs(), 4'b0000);
        tick();
        check("rst_no_done", dut_outs(), 4'b0000);
        reset = 1'b1;
        load = 1'b1; data = 16'h0005; len = 5'd3;
        tick();
        check("rst_reload_b0", dut_outs(), 4'b1110);
        load = 1'b0;
        tick();
        check("rst_reload_b1", dut_outs(), 4'b0110);
        tick();
        check("rst_reload_b2", dut_outs(), 4'b1110);
        tick();
        check("rst_reload_done", dut_outs(), 4'b0001);
        tick();
        check("rst_reload_idle", dut_outs(), 4'b0000);

`ifdef SERIALIZER_LOOP_EN
        // ---------------- loop mode ----------------
        loop = 1'b1;
        load = 1'b1; data = 16'h0005; len = 5'd3;
        for (int i = 0; i < 12; i++) begin
            if (i == 10) loop = 1'b0;
            tick();
            load = 1'b0;
            check($sformatf("loop_c%0d", i), dut_outs(), {(i % 3) != 1, 3'b110});
        end
        tick();
        check("loop_done", dut_outs(), 4'b0001);
        tick();
        check("loop_idle", dut_outs(), 4'b0000);
`endif

        // ---------------- randomized traffic vs. model ----------------
        check("model_sync", dut_outs(), model_outs());
        for (int c = 0; c < 600; c++) begin
            load = ($urandom_range(0, 2) == 0);
            data = WIDTH'($urandom);
            len  = LEN_W'($urandom_range(0, 31));
`ifdef SERIALIZER_LOOP_EN
            loop = ($urandom_range(0, 7) == 0);
`endif
            if ($urandom_range(0, 99) == 0) begin
                #1 reset = 1'b0;
                #1 check("rand_async_reset", dut_outs(), 4'b0000);
                reset = 1'b1;
            end
            tick();
            check($sformatf("rand_c%0d", c), dut_outs(), model_outs());
        end

        load = 1'b0;
`ifdef SERIALIZER_LOOP_EN
        loop = 1'b0;
`endif
        // Drain: with load and loop low the block must return to idle within one word plus DONE.
        repeat (WIDTH + 2) tick();
        check("drain_idle", dut_outs(), 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bit_stream_serializer.md
Name: bit_stream_serializer

Overview:
- Upstream feeder for the serial pattern-counter stage: loads a parallel word and shifts it out one bit per clock on a single serial line. The serial line drives the counter's `in` input.
- Provides valid/busy/done signalling so a controller or bench can queue words without counting clocks.
- Outputs are registered, so the counter samples one stable bit per rising edge.

Parameters:
- WIDTH, 16, maximum word length in bits.
- LEN_W, 5, width of the len port; must satisfy 2^LEN_W > WIDTH.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-low reset; reset=0 clears all state immediately.
- load  input  1  request to start a new word; sampled on the rising edge.
- data  input  WIDTH  word to send; bit len-1 is sent first, bit 0 last.
- len  input  LEN_W  number of bits to send (1..WIDTH).
- out  output  1  serial bit to the downstream counter.
- valid  output  1  out carries a word bit this cycle.
- busy  output  1  a word is in progress; load is ignored while high.
- done  output  1  one-cycle pulse in the cycle after the last bit.

Behaviour:
- Reset (reset=0, asynchronous):
  - out=0, valid=0, busy=0, done=0; state IDLE; shift register and bit counter cleared.
  - Takes effect mid-word with no completion pulse.
  - Release is synchronous to the next rising edge; first legal load is at that edge.
- States:
  - IDLE: busy=0, valid=0, out=0, done=0.
  - SHIFT: busy=1, valid=1.
  - DONE: one cycle; done=1, busy=0, valid=0, out=0.
- Load acceptance:
  - Accepted at a rising edge when busy=0 (IDLE or DONE) and load=1 and len!=0.
  - Captures data and the effective length L, where L = min(len, WIDTH).
  - len=0: load is ignored and the state is unchanged.
  - len>WIDTH: clamped to WIDTH.
- Latency:
  - Load accepted at edge k: out=data[L-1] and valid=1 are visible after edge k.
  - Bit data[L-1-i] is held from edge k+i to edge k+i+1, for i=0..L-1.
  - Exactly one clock per bit; no gaps within a word.
- Transitions:
  - After the bit-0 cycle (edge k+L): SHIFT→DONE, done=1 for exactly one cycle.
  - Then DONE→IDLE, or DONE→SHIFT if a load is accepted in the DONE cycle.
  - Minimum gap between back-to-back words is one cycle (the DONE cycle).
- Load while busy=1: ignored entirely. data and len are don't-care and the current word is unaffected.
- Changing data/len after acceptance has no effect; the word is held internally.
- out is forced to 0 whenever valid=0, so the downstream counter sees only 0s between words.
- Bit counter is LEN_W bits wide, decrements from L-1 to 0, and never wraps.

Optional Feature:
- Macro: SERIALIZER_LOOP_EN.
- Defined:
  - Adds input port `loop` (1 bit).
  - If loop=1 at the edge that ends bit 0, the captured word restarts at bit L-1 on that same edge. No DONE cycle, no done pulse, and valid stays 1.
  - If loop=0 at that edge, the block finishes normally via DONE.
  - loop has no effect in IDLE or DONE.
- Not defined: no `loop` port; every word ends via DONE.

Test Plan:
- Basic word: load data=16'h05D2, len=12 → over 12 cycles out = 0,1,0,1,1,1,0,1,0,0,1,0 with valid=1 and busy=1. Next cycle: done=1, valid=0, out=0. Then IDLE.
- Single bit, back-to-back: load data[0]=1, len=1 → one cycle out=1. Load again in the DONE cycle with data=16'h0002, len=2 → out = 1,0 immediately after DONE.
- Ignored loads:
  - load with data=16'hFFFF asserted during bit 3 of the basic word → sequence unchanged, no extra bits.
  - len=0 in IDLE → stays IDLE with all outputs 0.
  - len=20 with data=16'h8001 → 16 bits sent: 1, fourteen 0s, 1.
- Async reset mid-word: drive reset=0 between edges during bit 5 → out, valid and busy go 0 before the next edge, and no done pulse. After release, load 16'h0005/len=3 → out = 1,0,1.
- Loop mode (SERIALIZER_LOOP_EN): loop=1, data=3'b101, len=3 → out = 1,0,1,1,0,1,… continuously, valid=1, done=0. Drop loop during a repeat → that repeat completes, then done=1.
